// File: rtl/icache_responder_pkg.sv
// -----------------------------------------------------------------------------
// icache_responder_pkg
// Shared types and constants for the direct-mapped instruction cache.
//   icache_state_t : responder FSM states (IDLE, FILL)
//   icachef_t      : fetch address split {tag, idx, bytoff} for the default
//                    geometry (ICACHE_SETS frames)
//   icache_frame_t : one frame {valid, tag, data} for the default geometry
//   word_align()   : clears the byte offset of a byte address
// -----------------------------------------------------------------------------
package icache_responder_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  // Memory side only ever sees word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_frame_array.sv
// -----------------------------------------------------------------------------
// icache_frame_array
// Storage for the direct-mapped instruction cache: one valid bit, one tag and
// one data word per frame.
//   CLK, nRST        : clock, asynchronous active-low reset (clears valid bits)
//   clr_i            : synchronous bulk clear of every valid bit
//   we_i, widx_i,
//   wtag_i, wdata_i  : write port, installs a frame and sets its valid bit
//   ridx_i           : combinational read index
//   rvalid_o, rtag_o,
//   rdata_o          : read port outputs
// Bulk clear has priority over a write in the same cycle.
// -----------------------------------------------------------------------------
module icache_frame_array
  import icache_responder_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic             rvalid_o,
  output logic [TAG_W-1:0] rtag_o,
  output logic [31:0]      rdata_o
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  // Next valid vector: bulk clear first, then a single-frame install.
  always_comb begin
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[widx_i] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only state that needs reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data payload, written on install only.
  always_ff @(posedge CLK) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
// Direct-mapped, read-only instruction cache between the fetch stage and the
// memory arbiter. Hits are answered combinationally; a miss issues one
// single-word read, installs the returned word, then serves the hit.
//   CLK, nRST            : clock, asynchronous active-low reset
//   imemREN, imemaddr    : fetch request / byte address (bits [1:0] ignored)
//   ihit, imemload       : hit strobe and instruction word (0 when no hit)
//   iinvalidate          : one-cycle pulse clearing every valid bit
//   iREN, iaddr          : memory read request / word address (held in FILL)
//   iwait, iload         : memory busy / read data (taken when iREN && !iwait)
// Optional build macro ICACHE_STATS_EN adds saturating hit_count and
// miss_count outputs; without it the core behaviour is identical.
// -----------------------------------------------------------------------------
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iinvalidate,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic          drop_q, drop_d;

  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic [IDX_W-1:0] miss_idx_s;
  logic [TAG_W-1:0] miss_tag_s;
  logic             rvalid_s;
  logic [TAG_W-1:0] rtag_s;
  logic [31:0]      rdata_s;
  logic             lookup_hit_s;
  logic             fill_we_s;
  logic             start_fill_s;
  logic             unused_s;

  assign req_idx_s    = imemaddr[IDX_W+1:2];
  assign req_tag_s    = imemaddr[31:IDX_W+2];
  assign miss_idx_s   = miss_addr_q[IDX_W+1:2];
  assign miss_tag_s   = miss_addr_q[31:IDX_W+2];
  assign lookup_hit_s = imemREN && rvalid_s && (rtag_s == req_tag_s);
  assign unused_s     = ^imemaddr[1:0];

  icache_frame_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr_i    (iinvalidate),
    .we_i     (fill_we_s),
    .widx_i   (miss_idx_s),
    .wtag_i   (miss_tag_s),
    .wdata_i  (iload),
    .ridx_i   (req_idx_s),
    .rvalid_o (rvalid_s),
    .rtag_o   (rtag_s),
    .rdata_o  (rdata_s)
  );

  // FSM next state, fill control and datapath-facing outputs.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    drop_d       = drop_q;
    ihit         = 1'b0;
    imemload     = 32'h0000_0000;
    iREN         = 1'b0;
    iaddr        = 32'h0000_0000;
    fill_we_s    = 1'b0;
    start_fill_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (iinvalidate) begin
          // Every frame is being cleared this edge: no hit, no new fill.
          state_d = IDLE;
        end else if (lookup_hit_s) begin
          ihit     = 1'b1;
          imemload = rdata_s;
        end else if (imemREN) begin
          miss_addr_d  = word_align(imemaddr);
          drop_d       = 1'b0;
          start_fill_s = 1'b1;
          state_d      = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          // An invalidate anywhere in the fill, including this edge, drops it.
          fill_we_s = !(drop_q || iinvalidate);
          drop_d    = 1'b0;
          state_d   = IDLE;
        end else if (iinvalidate) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, latched miss address and sticky drop flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0000_0000;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      drop_q      <= drop_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Saturating statistics; deliberately untouched by iinvalidate.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= 32'h0000_0000;
      miss_count_q <= 32'h0000_0000;
    end else begin
      if (ihit && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (start_fill_s && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = start_fill_s;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
// Directed bench for icache_responder (SETS = 16). A memory responder answers
// fills with a programmable number of wait cycles; a reference model keeps the
// set of installed word addresses per index and is compared with the DUT every
// cycle, while directed steps pin literal values from the test scenarios.
// -----------------------------------------------------------------------------
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iinvalidate = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wait = 3;
  int wcnt     = 0;

  icache_responder dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .ihit        (ihit),
    .imemload    (imemload),
    .iinvalidate (iinvalidate),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return (a * 32'd3) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: mem_wait busy cycles, then one data cycle.
  always @(negedge CLK) begin
    if (!nRST || !iREN) begin
      iwait = 1'b1;
      iload = 32'hDEAD_BEEF;
      wcnt  = 0;
    end else if (wcnt < mem_wait) begin
      iwait = 1'b1;
      iload = 32'hDEAD_BEEF;
      wcnt++;
    end else begin
      iwait = 1'b0;
      iload = mem_word(iaddr);
      wcnt  = 0;
    end
  end

  // Reference model: which word address each index currently holds.
  logic [31:0] m_line [int];
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_miss = 32'h0;
  logic [31:0] c_wa;
  int          c_idx;
  bit          c_hit;

  always @(negedge CLK) begin
    #2;
    if (!nRST) begin
      m_line.delete();
      m_busy = 1'b0;
      m_drop = 1'b0;
      chk("rst_ihit", {31'd0, ihit}, 32'd0);
      chk("rst_iren", {31'd0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_imemload", imemload, 32'd0);
    end else begin
      c_wa  = {imemaddr[31:2], 2'b00};
      c_idx = int'(imemaddr[5:2]);
      c_hit = !m_busy && imemREN && !iinvalidate && m_line.exists(c_idx) && (m_line[c_idx] == c_wa);
      chk("m_ihit", {31'd0, ihit}, {31'd0, c_hit});
      chk("m_imemload", imemload, c_hit ? mem_word(c_wa) : 32'd0);
      chk("m_iren", {31'd0, iREN}, {31'd0, m_busy});
      chk("m_iaddr", iaddr, m_busy ? m_miss : 32'd0);
      if (!m_busy) begin
        if (iinvalidate) begin
          m_line.delete();
        end else if (imemREN && !c_hit) begin
          m_busy = 1'b1;
          m_miss = c_wa;
          m_drop = 1'b0;
        end
      end else begin
        if (iinvalidate) begin
          m_line.delete();
          m_drop = 1'b1;
        end
        if (!iwait) begin
          if (!m_drop) m_line[int'(m_miss[5:2])] = m_miss;
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // From posedge+1 to 2 time units after the following negedge.
  task automatic sample();
    #6;
  endtask

  task automatic drive(input logic ren, input logic [31:0] a, input logic inv);
    imemREN     = ren;
    imemaddr    = a;
    iinvalidate = inv;
  endtask

  // Run until the current request hits; checks fill length and hit data.
  task automatic wait_hit(input string nm, input int exp_ren, input logic [31:0] exp_data);
    int ren = 0;
    bit got = 1'b0;
    bit last_ren = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (ihit) begin
        got = 1'b1;
        break;
      end
      last_ren = iREN;
      if (iREN) ren++;
      tick();
    end
    chk({nm, "_hit"}, {31'd0, got}, 32'd1);
    chk({nm, "_data"}, imemload, exp_data);
    if (exp_ren >= 0) begin
      chk({nm, "_ren_cycles"}, ren, exp_ren);
      chk({nm, "_hit_after_fill"}, {31'd0, last_ren}, 32'd1);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ihit", {31'd0, ihit}, 32'd0);
    chk("reset_iren", {31'd0, iREN}, 32'd0);
    chk("reset_iaddr", iaddr, 32'd0);
    chk("reset_imemload", imemload, 32'd0);
    #2;
    nRST = 1'b1;
    tick();

    // Cold miss: 3 wait cycles -> iREN for 4 cycles, then the hit
    drive(1'b1, 32'h0000_0040, 1'b0);
    sample();
    chk("cold_first_cycle_iren", {31'd0, iREN}, 32'd0);
    tick();
    wait_hit("cold", 4, 32'h2001_0005);

    // Hit with byte offset ignored
    drive(1'b1, 32'h0000_0043, 1'b0);
    sample();
    chk("offset_hit", {31'd0, ihit}, 32'd1);
    chk("offset_data", imemload, 32'h2001_0005);
    chk("offset_iren", {31'd0, iREN}, 32'd0);
    tick();

    // Idle with no request
    drive(1'b0, 32'h0000_0040, 1'b0);
    sample();
    chk("noreq_ihit", {31'd0, ihit}, 32'd0);
    tick();

    // Same-index conflict: 0x80 evicts 0x40
    drive(1'b1, 32'h0000_0080, 1'b0);
    wait_hit("conflict80", 4, mem_word(32'h0000_0080));
    drive(1'b1, 32'h0000_0040, 1'b0);
    sample();
    chk("conflict40_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("refill40", 4, 32'h2001_0005);

    // Redirect mid-fill: 0x100 fill completes, then 0x200 is fetched
    drive(1'b1, 32'h0000_0100, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!iREN) break;
      chk("redir_iaddr_stable", iaddr, 32'h0000_0100);
      tick();
    end
    chk("redir_200_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("redir200", 4, mem_word(32'h0000_0200));
    // Redirect across indices: 0x104 must be installed after the redirect
    drive(1'b1, 32'h0000_0104, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0208, 1'b0);
    wait_hit("redir208", -1, mem_word(32'h0000_0208));
    drive(1'b1, 32'h0000_0104, 1'b0);
    sample();
    chk("redir_104_installed", {31'd0, ihit}, 32'd1);
    chk("redir_104_data", imemload, mem_word(32'h0000_0104));
    tick();

    // Invalidate during FILL
    drive(1'b1, 32'h0000_004C, 1'b0);
    wait_hit("fill4c", 4, mem_word(32'h0000_004C));
    drive(1'b1, 32'h0000_0300, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0300, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0300, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!iREN) break;
      tick();
    end
    chk("inv_300_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("refill300", 4, mem_word(32'h0000_0300));
    drive(1'b1, 32'h0000_004C, 1'b0);
    sample();
    chk("inv_4c_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("refill4c", 4, mem_word(32'h0000_004C));

    // Invalidate coinciding with the completing edge
    mem_wait = 0;
    drive(1'b1, 32'h0000_0050, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0050, 1'b1);
    sample();
    chk("edge_inv_iren", {31'd0, iREN}, 32'd1);
    tick();
    drive(1'b1, 32'h0000_0050, 1'b0);
    sample();
    chk("edge_inv_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("refill50", 1, mem_word(32'h0000_0050));
    mem_wait = 3;
    drive(1'b1, 32'h0000_004C, 1'b0);
    wait_hit("refill4c_b", -1, mem_word(32'h0000_004C));

    // Asynchronous reset mid-FILL
    drive(1'b1, 32'h0000_0054, 1'b0);
    tick();
    #2;
    chk("pre_rst_iren", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_iren", {31'd0, iREN}, 32'd0);
    chk("rst_mid_iaddr", iaddr, 32'd0);
    drive(1'b0, 32'h0000_0000, 1'b0);
    @(negedge CLK);
    #4;
    nRST = 1'b1;
    tick();
    drive(1'b1, 32'h0000_004C, 1'b0);
    sample();
    chk("post_rst_4c_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("post_rst_fill", 4, mem_word(32'h0000_004C));
    drive(1'b1, 32'h0000_0050, 1'b0);
    sample();
    chk("post_rst_50_miss", {31'd0, ihit}, 32'd0);
    tick();
    wait_hit("post_rst_fill50", 4, mem_word(32'h0000_0050));

    drive(1'b0, 32'h0000_0000, 1'b0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
